wb4_ram_slave: RTL and testbench

- Wishbone B4 classic-cycle responder: word-addressed single-port RAM with byte-lane writes and a programmable wait-state count.
- Sits on the far side of the core's instruction and data buses. It is the memory target for fetch, load and store traffic in simulation and FPGA builds.
- One instance per bus, or one instance behind an arbiter.

---
 rtl/wb4_ram_slave_if.sv | 18 +
 rtl/wb4_ram_slave.sv | 123 ++++++++++++
 tb/tb_wb4_ram_slave.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb4_ram_slave_if.sv
// Wishbone B4 classic-cycle bus bundle between a master and the RAM responder.
interface wb4_ram_slave_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack;
   logic        err;
   logic        stall;

   modport master (output cyc, stb, we, adr, sel, dat_i,
                   input  dat_o, ack, err, stall);
   modport slave  (input  cyc, stb, we, adr, sel, dat_i,
                   output dat_o, ack, err, stall);
endinterface

// File: rtl/wb4_ram_slave.sv
// Wishbone B4 classic RAM responder with byte lanes and WAIT_STATES wait cycles.
// Define WB4_RAM_ERR_EN to terminate out-of-window or misaligned accesses with err.
module wb4_ram_slave #(
   parameter int          DEPTH       = 1024,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter              INIT_FILE   = ""
) (
   input logic            clk,
   input logic            rst,
   wb4_ram_slave_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [31:0] mem [DEPTH];

   initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        we_reg;
   logic [31:0] adr_reg;
   logic [3:0]  sel_reg;
   logic [31:0] dat_reg;
   logic        ack_reg;
   logic        err_reg;
   logic [31:0] dat_o_reg;

   logic          idle;
   logic          req_we;
   logic [31:0]   req_adr;
   logic [3:0]    req_sel;
   logic [31:0]   req_dat;
   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          bad;
   logic          resp_go;

   // With no wait states the RESP-entry edge is the capture edge, so use live inputs.
   assign idle    = (state_reg == S_IDLE);
   assign req_we  = idle ? bus.we    : we_reg;
   assign req_adr = idle ? bus.adr   : adr_reg;
   assign req_sel = idle ? bus.sel   : sel_reg;
   assign req_dat = idle ? bus.dat_i : dat_reg;
   assign off     = req_adr - BASE_ADDR;
   assign idx     = off[AW+1:2];
   assign resp_go = (state_next == S_RESP);

`ifdef WB4_RAM_ERR_EN
   assign bad = (off[31:AW+2] != '0)
              || ((req_adr[1:0] != 2'b00) && (req_sel == 4'b1111))
              || (req_adr[0] && ((req_sel == 4'b0011) || (req_sel == 4'b1100)));
`else
   logic unused_off;
   assign bad        = 1'b0;
   assign unused_off = &{1'b0, off[31:AW+2], off[1:0]};
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         S_IDLE: begin
            if (bus.cyc && bus.stb) begin
               cnt_next   = 4'(WAIT_STATES);
               state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (!bus.cyc) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) state_next = S_RESP;
            end
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         we_reg    <= 1'b0;
         adr_reg   <= '0;
         sel_reg   <= '0;
         dat_reg   <= '0;
         ack_reg   <= 1'b0;
         err_reg   <= 1'b0;
         dat_o_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (idle && bus.cyc && bus.stb) begin
            we_reg  <= bus.we;
            adr_reg <= bus.adr;
            sel_reg <= bus.sel;
            dat_reg <= bus.dat_i;
         end
         ack_reg <= resp_go && !bad;
         err_reg <= resp_go && bad;
         if (resp_go && !req_we && !bad) dat_o_reg <= mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && resp_go && req_we && !bad) begin
         for (int b = 0; b < 4; b++) begin
            if (req_sel[b]) mem[idx][8*b +: 8] <= req_dat[8*b +: 8];
         end
      end
   end

   assign bus.ack   = ack_reg;
   assign bus.err   = err_reg;
   assign bus.dat_o = dat_o_reg;
   assign bus.stall = !idle;
endmodule

// File: tb/tb_wb4_ram_slave.sv
// Scoreboard bench: dut0 runs with no wait states, dut3 with three; both DEPTH=1024.
module tb_wb4_ram_slave;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb4_ram_slave_if bus0();
   wb4_ram_slave_if bus3();

   wb4_ram_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   wb4_ram_slave #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   logic [1:0]  cyc_d, stb_d, we_d;
   logic [31:0] adr_d [2];
   logic [3:0]  sel_d [2];
   logic [31:0] wd_d  [2];

   assign bus0.cyc = cyc_d[0];  assign bus3.cyc = cyc_d[1];
   assign bus0.stb = stb_d[0];  assign bus3.stb = stb_d[1];
   assign bus0.we  = we_d[0];   assign bus3.we  = we_d[1];
   assign bus0.adr = adr_d[0];  assign bus3.adr = adr_d[1];
   assign bus0.sel = sel_d[0];  assign bus3.sel = sel_d[1];
   assign bus0.dat_i = wd_d[0]; assign bus3.dat_i = wd_d[1];

   typedef struct packed {
      logic        ack;
      logic        err;
      logic [7:0]  lat;
      logic [7:0]  stall_n;
      logic [31:0] data;
   } resp_t;

   resp_t       exp_q [$];
   resp_t       obs_q [$];
   resp_t       last_obs;
   logic [31:0] m0 [int];
   logic [31:0] m3 [int];
   logic [31:0] last_rd [2];
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic logic ack_of(int d);   return (d == 0) ? bus0.ack   : bus3.ack;   endfunction
   function automatic logic err_of(int d);   return (d == 0) ? bus0.err   : bus3.err;   endfunction
   function automatic logic stall_of(int d); return (d == 0) ? bus0.stall : bus3.stall; endfunction
   function automatic logic [31:0] dout_of(int d); return (d == 0) ? bus0.dat_o : bus3.dat_o; endfunction

   function automatic logic [31:0] mget(int d, int i);
      if (d == 0) return m0.exists(i) ? m0[i] : 32'h0;
      return m3.exists(i) ? m3[i] : 32'h0;
   endfunction

   function automatic void mset(int d, int i, logic [31:0] v);
      if (d == 0) m0[i] = v;
      else        m3[i] = v;
   endfunction

   // Reference behaviour of one completed transfer; also advances the memory model.
   function automatic resp_t predict(int d, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] wd);
      resp_t       r;
      int          ws;
      int          i;
      logic        bad;
      logic [31:0] v;
      ws  = (d == 0) ? 0 : 3;
      i   = int'((a >> 2) & 32'h3FF);
      bad = 1'b0;
`ifdef WB4_RAM_ERR_EN
      bad = (a >= 32'h1000) || ((a[1:0] != 2'b00) && (s == 4'hF))
         || (a[0] && ((s == 4'h3) || (s == 4'hC)));
`endif
      r         = '0;
      r.ack     = !bad;
      r.err     = bad;
      r.lat     = 8'(ws + 1);
      r.stall_n = 8'(ws + 1);
      if (bad) begin
         r.data = w ? 32'h0 : last_rd[d];
      end else if (w) begin
         v = mget(d, i);
         for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = wd[8*b +: 8];
         mset(d, i, v);
      end else begin
         r.data     = mget(d, i);
         last_rd[d] = r.data;
      end
      return r;
   endfunction

   task automatic drive(input int d, input logic c, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd);
      cyc_d[d] = c;
      stb_d[d] = c;
      we_d[d]  = w;
      adr_d[d] = a;
      sel_d[d] = s;
      wd_d[d]  = wd;
   endtask

   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, output resp_t o);
      int lat;
      int sn;
      bit done;
      o    = '0;
      lat  = 0;
      sn   = 0;
      done = 0;
      drive(d, 1'b1, w, a, s, wd);
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (stall_of(d)) sn++;
         if (ack_of(d) || err_of(d)) begin
            done   = 1;
            o.ack  = ack_of(d);
            o.err  = err_of(d);
            o.data = w ? 32'h0 : dout_of(d);
         end
      end
      drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      o.lat     = 8'(lat);
      o.stall_n = 8'(sn);
      $display("TXN dut%0d we=%0b adr=%h sel=%b wdat=%h ack=%0b err=%0b lat=%0d stall_cycles=%0d rdat=%h",
               d, w, a, s, wd, o.ack, o.err, lat, sn, o.data);
      @(posedge clk); #1;
   endtask

   task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd);
      resp_t o;
      exp_q.push_back(predict(d, w, a, s, wd));
      xfer(d, w, a, s, wd, o);
      obs_q.push_back(o);
      last_obs = o;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({bus0.ack, bus0.err, bus0.stall, bus0.dat_o} !== 35'h0) begin
         n_errors++;
         $display("FAIL reset_dut0 ack/err/stall/dat_o got %b/%b/%b/%h required 0/0/0/00000000",
                  bus0.ack, bus0.err, bus0.stall, bus0.dat_o);
      end
      n_checks++;
      if ({bus3.ack, bus3.err, bus3.stall, bus3.dat_o} !== 35'h0) begin
         n_errors++;
         $display("FAIL reset_dut3 ack/err/stall/dat_o got %b/%b/%b/%h required 0/0/0/00000000",
                  bus3.ack, bus3.err, bus3.stall, bus3.dat_o);
      end
      drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({bus0.ack, bus0.stall} !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_req_ignored ack/stall got %b/%b required 0/0", bus0.ack, bus0.stall);
      end
      $display("TXN dut0 request held during reset ack=%0b stall=%0b", bus0.ack, bus0.stall);
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      resp_t o, e;
      issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      issue(0, 1'b0, 32'h10, 4'hF, 32'h0);
      n_checks++;
      if (last_obs.data !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL basic_readback got %h required deadbeef", last_obs.data);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL basic ack/err/lat/stall/data got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_byte_lanes;
      resp_t o, e;
      issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
      issue(0, 1'b1, 32'h20, 4'b0100, 32'h00AA0000);
      issue(0, 1'b0, 32'h20, 4'b0001, 32'h0);
      n_checks++;
      if (last_obs.data !== 32'h11AA3344) begin
         n_errors++;
         $display("FAIL byte_lane_merge got %h required 11aa3344", last_obs.data);
      end
      issue(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
      issue(0, 1'b1, 32'h24, 4'b1001, 32'hA5C3C35A);
      issue(0, 1'b0, 32'h20, 4'hF, 32'h0);
      issue(0, 1'b0, 32'h24, 4'hF, 32'h0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL byte_lanes ack/err/lat/stall/data got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_wait_states;
      resp_t o, e;
      issue(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D);
      issue(1, 1'b0, 32'h10, 4'hF, 32'h0);
      issue(1, 1'b1, 32'h14, 4'b0011, 32'h00001234);
      issue(1, 1'b0, 32'h14, 4'hF, 32'h0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL wait_states ack/err/lat/stall/data got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_abort;
      resp_t o, e;
      bit    seen;
      logic  stall_after;
      issue(1, 1'b1, 32'h40, 4'hF, 32'hAAAA5555);
      drive(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h12345678);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      seen = 0;
      stall_after = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (c == 0) stall_after = bus3.stall;
         if (bus3.ack || bus3.err) seen = 1;
      end
      $display("TXN dut3 write adr=00000040 aborted in wait ack_seen=%0b", seen);
      n_checks++;
      if (seen || stall_after !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_no_ack ack_seen/stall got %0b/%b required 0/0", seen, stall_after);
      end
      issue(1, 1'b0, 32'h40, 4'hF, 32'h0);
      n_checks++;
      if (last_obs.data !== 32'hAAAA5555) begin
         n_errors++;
         $display("FAIL abort_mem_unchanged got %h required aaaa5555", last_obs.data);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL abort ack/err/lat/stall/data got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_reset_mid;
      resp_t o, e;
      bit    seen;
      issue(1, 1'b1, 32'h44, 4'hF, 32'h0BADF00D);
      drive(1, 1'b1, 1'b1, 32'h44, 4'hF, 32'h55555555);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({bus3.ack, bus3.err, bus3.stall} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_mid ack/err/stall got %b/%b/%b required 0/0/0", bus3.ack, bus3.err, bus3.stall);
      end
      rst = 1'b0;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (bus3.ack || bus3.err) seen = 1;
      end
      $display("TXN dut3 write adr=00000044 reset in wait ack_seen=%0b", seen);
      n_checks++;
      if (seen) begin
         n_errors++;
         $display("FAIL reset_mid_late_ack ack_seen got 1 required 0");
      end
      issue(1, 1'b0, 32'h44, 4'hF, 32'h0);
      n_checks++;
      if (last_obs.data !== 32'h0BADF00D) begin
         n_errors++;
         $display("FAIL reset_mid_mem_unchanged got %h required 0badf00d", last_obs.data);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL reset_mid ack/err/lat/stall/data got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_back_to_back;
      resp_t o, e;
      int    k;
      int    exp_cyc [3];
      exp_cyc = '{1, 3, 5};
      issue(0, 1'b1, 32'h0, 4'hF, 32'h01010101);
      issue(0, 1'b1, 32'h4, 4'hF, 32'h02020202);
      issue(0, 1'b1, 32'h8, 4'hF, 32'h03030303);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL b2b_setup ack/err/lat/stall/data got %h required %h", o, e);
         end
      end
      for (int j = 0; j < 3; j++) exp_q.push_back(predict(0, 1'b0, 32'(4 * j), 4'hF, 32'h0));
      k = 0;
      drive(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      for (int c = 1; c <= 20 && k < 3; c++) begin
         @(posedge clk); #1;
         if (bus0.ack) begin
            e = exp_q.pop_front();
            $display("TXN dut0 b2b read %0d ack_cycle=%0d rdat=%h", k, c, bus0.dat_o);
            n_checks++;
            if (c != exp_cyc[k] || bus0.dat_o !== e.data) begin
               n_errors++;
               $display("FAIL b2b_read%0d cycle/data got %0d/%h required %0d/%h",
                        k, c, bus0.dat_o, exp_cyc[k], e.data);
            end
            k++;
            if (k < 3) adr_d[0] = 32'(4 * k);
         end
      end
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      n_checks++;
      if (k != 3) begin
         n_errors++;
         $display("FAIL b2b_timeout acks got %0d required 3", k);
      end
      exp_q.delete();
   endtask

   task automatic test_window;
      resp_t o, e;
`ifdef WB4_RAM_ERR_EN
      issue(0, 1'b0, 32'h1000, 4'hF, 32'h0);
      issue(0, 1'b1, 32'h22, 4'hF, 32'hFFFFFFFF);
      issue(0, 1'b1, 32'h21, 4'b0011, 32'hFFFFFFFF);
      issue(0, 1'b0, 32'h20, 4'hF, 32'h0);
      n_checks++;
      if (last_obs.data !== 32'h11AA3344) begin
         n_errors++;
         $display("FAIL err_no_write got %h required 11aa3344", last_obs.data);
      end
`else
      issue(0, 1'b0, 32'h1000, 4'hF, 32'h0);
      n_checks++;
      if (last_obs.data !== 32'h01010101) begin
         n_errors++;
         $display("FAIL alias_read got %h required 01010101", last_obs.data);
      end
      issue(0, 1'b1, 32'h1006, 4'b1100, 32'hBEEF0000);
      issue(0, 1'b0, 32'h4, 4'hF, 32'h0);
`endif
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL window ack/err/lat/stall/data got %h required %h", o, e);
         end
      end
   endtask

   initial begin
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      last_obs   = '0;
      test_reset();
      test_basic();
      test_byte_lanes();
      test_wait_states();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_window();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
